excp_commit: RTL and testbench

Writeback-stage exception/ERTN commit controller for the LoongArch pipeline. It drives the CSR file's exception-response port: `excp`, `excp_tlbrefill`, `ertn`, `era`, `code`, `subcode`, `badv_addr` and `excpAboutAddr`. It consumes the CSR file's `has_int`, `eentry_out`, `tlbrentry_out` and `era_out`. It prioritises the exception sources, cancels the faulting instruction, flushes the pipeline, and holds a redirect PC toward preIF until preIF accepts it.

---
 rtl/excp_commit_if.sv | 27 ++
 rtl/excp_commit.sv | 166 ++++++++++++++++
 tb/tb_excp_commit.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/excp_commit_if.sv
// ---------------------------------------------------------------------------
// excp_commit_if
// Redirect handshake between the writeback exception/ERTN commit controller
// and the preIF stage.
//   redirect_valid  : redirect PC is valid (controller -> preIF)
//   redirect_pc     : redirect target, 32 bits (controller -> preIF)
//   redirect_ready  : preIF accepts the redirect (preIF -> controller)
// modport master : the commit controller side
// modport slave  : the preIF side
// ---------------------------------------------------------------------------
interface excp_commit_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;

   modport master (
      output redirect_valid,
      output redirect_pc,
      input  redirect_ready
   );

   modport slave (
      input  redirect_valid,
      input  redirect_pc,
      output redirect_ready
   );
endinterface

// File: rtl/excp_commit.sv
// ---------------------------------------------------------------------------
// excp_commit
// Writeback-stage exception / ERTN commit controller. Picks the winning
// exception source of the WB instruction, drives the CSR file's exception
// response port for exactly one cycle, cancels the faulting instruction,
// flushes the pipeline, and holds a redirect PC toward preIF until accepted.
//
// Ports
//   clk, reset        clock and synchronous active-high reset
//   ws_valid/ws_pc    WB instruction present / its PC
//   ws_excp_vec[5:0]  {ale, brk, sys, ine, tlbr, adef}
//   ws_vaddr          faulting vaddr for ALE/TLBR
//   ws_is_ertn        WB instruction is ERTN
//   has_int           pending enabled interrupt
//   eentry_in, tlbrentry_in, era_in   CSR vectors and return address
//   excp, excp_tlbrefill, ertn, era, code, subcode, badv_addr,
//   excpAboutAddr     CSR exception-response port (combinational, cycle C)
//   ws_cancel         suppress writeback of the WB instruction
//   flush             kill all pipeline stages
//   redir             redirect handshake (excp_commit_if.master)
//
// Build option
//   EXCP_TLBR_EN  defined: TLB-refill source decoded, excp_tlbrefill driven,
//                 tlbrentry_in used. Undefined: ws_excp_vec[1] ignored,
//                 excp_tlbrefill tied 0.
// ---------------------------------------------------------------------------
module excp_commit (
   input  logic               clk,
   input  logic               reset,
   input  logic               ws_valid,
   input  logic [31:0]        ws_pc,
   input  logic [5:0]         ws_excp_vec,
   input  logic [31:0]        ws_vaddr,
   input  logic               ws_is_ertn,
   input  logic               has_int,
   input  logic [31:0]        eentry_in,
   input  logic [31:0]        tlbrentry_in,
   input  logic [31:0]        era_in,
   output logic               excp,
   output logic               excp_tlbrefill,
   output logic               ertn,
   output logic [31:0]        era,
   output logic [5:0]         code,
   output logic [8:0]         subcode,
   output logic [31:0]        badv_addr,
   output logic               excpAboutAddr,
   output logic               ws_cancel,
   output logic               flush,
   excp_commit_if.master      redir
);

   typedef enum logic {IDLE, REDIRECT} state_t;

   // Source index order is the priority order, highest first:
   // 0 INT, 1 ADEF, 2 TLBR, 3 INE, 4 SYS, 5 BRK, 6 ALE
   localparam int NSRC = 7;
   localparam logic [5:0] EXC_CODE [0:NSRC-1] =
      '{6'h00, 6'h08, 6'h3F, 6'h0D, 6'h0B, 6'h0C, 6'h09};

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [5:0]  vec_eff;
   logic [NSRC-1:0] src;
   logic [NSRC-1:0] win;
   logic        any_excp;
   logic        commit;

`ifdef EXCP_TLBR_EN
   assign vec_eff = ws_excp_vec;
`else
   // Without TLB refill support the TLBR flag is dropped, which also leaves
   // the remaining sources in INT>ADEF>INE>SYS>BRK>ALE order.
   assign vec_eff = {ws_excp_vec[5:2], 1'b0, ws_excp_vec[0]};
   logic [32:0] tlbr_unused;
   assign tlbr_unused = {ws_excp_vec[1], tlbrentry_in};
`endif

   assign src = {vec_eff[5], vec_eff[4], vec_eff[3], vec_eff[2],
                 vec_eff[1], vec_eff[0], has_int};

   // One-hot winner: a source wins when no higher-priority source is set.
   genvar gi;
   generate
      for (gi = 0; gi < NSRC; gi++) begin : g_win
         if (gi == 0) begin : g_top
            assign win[gi] = src[gi];
         end else begin : g_rest
            assign win[gi] = src[gi] & ~(|src[gi-1:0]);
         end
      end
   endgenerate

   assign any_excp = |src;
   // Reset gates the commit so no strobe leaks out while reset is held.
   assign commit   = (state_reg == IDLE) & ws_valid & (any_excp | ws_is_ertn)
                     & ~reset;

   always_comb begin
      state_next     = state_reg;
      pc_next        = pc_reg;
      excp           = 1'b0;
      excp_tlbrefill = 1'b0;
      ertn           = 1'b0;
      era            = 32'h0;
      code           = 6'h00;
      subcode        = 9'h000;
      badv_addr      = 32'h0;
      excpAboutAddr  = 1'b0;
      ws_cancel      = 1'b0;
      flush          = 1'b0;
      case (state_reg)
         IDLE: begin
            if (commit) begin
               state_next = REDIRECT;
               flush      = 1'b1;
               if (any_excp) begin
                  // Any exception, interrupts included, overrides ERTN.
                  excp      = 1'b1;
                  ws_cancel = 1'b1;
                  era       = ws_pc;
                  for (int i = 0; i < NSRC; i++) begin
                     if (win[i]) code = EXC_CODE[i];
                  end
                  if (win[1]) begin
                     excpAboutAddr = 1'b1;
                     badv_addr     = ws_pc;
                  end
                  if (win[2] | win[6]) begin
                     excpAboutAddr = 1'b1;
                     badv_addr     = ws_vaddr;
                  end
                  pc_next = eentry_in;
`ifdef EXCP_TLBR_EN
                  excp_tlbrefill = win[2];
                  if (win[2]) pc_next = tlbrentry_in;
`endif
               end else begin
                  // ERTN retires; return to the ERA value before this
                  // cycle's CSR update.
                  ertn    = 1'b1;
                  pc_next = era_in;
               end
            end
         end
         REDIRECT: begin
            flush = 1'b1;
            if (redir.redirect_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         pc_reg    <= 32'h0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
      end
   end

   assign redir.redirect_valid = (state_reg == REDIRECT);
   assign redir.redirect_pc    = pc_reg;

endmodule

// File: tb/tb_excp_commit.sv
// ---------------------------------------------------------------------------
// tb_excp_commit
// Scoreboard bench for excp_commit. The driver applies directed and random
// stimulus, evaluates the commit rules on each cycle and queues the expected
// CSR response and redirect target; a negedge monitor pops and compares.
// ws_excp_vec bit map: [5] ale, [4] brk, [3] sys, [2] ine, [1] tlbr, [0] adef
// ---------------------------------------------------------------------------
module tb_excp_commit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        ws_valid;
   logic [31:0] ws_pc;
   logic [5:0]  ws_excp_vec;
   logic [31:0] ws_vaddr;
   logic        ws_is_ertn;
   logic        has_int;
   logic [31:0] eentry_in, tlbrentry_in, era_in;
   logic        excp, excp_tlbrefill, ertn;
   logic [31:0] era;
   logic [5:0]  code;
   logic [8:0]  subcode;
   logic [31:0] badv_addr;
   logic        excpAboutAddr, ws_cancel, flush;
   logic        ready;

   excp_commit_if rif ();
   assign rif.redirect_ready = ready;

   excp_commit dut (
      .clk(clk), .reset(reset),
      .ws_valid(ws_valid), .ws_pc(ws_pc), .ws_excp_vec(ws_excp_vec),
      .ws_vaddr(ws_vaddr), .ws_is_ertn(ws_is_ertn), .has_int(has_int),
      .eentry_in(eentry_in), .tlbrentry_in(tlbrentry_in), .era_in(era_in),
      .excp(excp), .excp_tlbrefill(excp_tlbrefill), .ertn(ertn), .era(era),
      .code(code), .subcode(subcode), .badv_addr(badv_addr),
      .excpAboutAddr(excpAboutAddr), .ws_cancel(ws_cancel), .flush(flush),
      .redir(rif)
   );

   typedef struct {
      logic        is_excp;
      logic [5:0]  code;
      logic [31:0] era;
      logic        about;
      logic [31:0] badv;
      logic        tlbr;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] tgt_q[$];

   int   errors = 0;
   int   checks = 0;
   logic busy = 1'b0;       // a redirect is outstanding toward preIF
   logic mon_en = 1'b0;
   logic exp_commit = 1'b0, exp_flush = 1'b0, exp_rv = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   // Evaluate the commit rules for the inputs currently applied, queue the
   // expected response, then advance one clock.
   task automatic tick();
      logic [5:0]  v;
      logic        hit [0:6];
      logic [5:0]  codes [0:6];
      int          w;
      exp_t        e;
      logic [31:0] tgt;
      logic        busy_n;
      v = ws_excp_vec;
`ifndef EXCP_TLBR_EN
      v[1] = 1'b0;
`endif
      hit   = '{has_int, v[0], v[1], v[2], v[3], v[4], v[5]};
      codes = '{6'h00, 6'h08, 6'h3F, 6'h0D, 6'h0B, 6'h0C, 6'h09};
      w = -1;
      for (int i = 6; i >= 0; i--) if (hit[i]) w = i;
      exp_commit = !reset && !busy && ws_valid && (w >= 0 || ws_is_ertn);
      exp_flush  = busy || exp_commit;
      exp_rv     = busy;
      if (exp_commit) begin
         if (w >= 0) begin
            e.is_excp = 1'b1;
            e.code    = codes[w];
            e.era     = ws_pc;
            e.tlbr    = (w == 2);
            e.about   = (w == 1 || w == 2 || w == 6);
            e.badv    = (w == 1) ? ws_pc : ws_vaddr;
            tgt       = (w == 2) ? tlbrentry_in : eentry_in;
         end else begin
            e = '{1'b0, 6'h0, 32'h0, 1'b0, 32'h0, 1'b0};
            tgt = era_in;
         end
         exp_q.push_back(e);
         tgt_q.push_back(tgt);
      end
      if (reset)      busy_n = 1'b0;
      else if (busy)  busy_n = !ready;
      else            busy_n = exp_commit;
      @(posedge clk);
      #1;
      busy = busy_n;
   endtask

   task automatic drv(input logic v, input logic [5:0] ve, input logic [31:0] p,
                      input logic [31:0] va, input logic er, input logic it,
                      input logic rd);
      ws_valid = v; ws_excp_vec = ve; ws_pc = p; ws_vaddr = va;
      ws_is_ertn = er; has_int = it; ready = rd;
      tick();
   endtask

   // Monitor
   logic        prev_rv = 1'b0;
   logic [31:0] held_pc = 32'h0;
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         chk("redirect_valid", {31'h0, rif.redirect_valid}, {31'h0, exp_rv});
         chk("flush", {31'h0, flush}, {31'h0, exp_flush});
         chk("strobe", {31'h0, excp | ertn}, {31'h0, exp_commit});
         if (excp | ertn) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_commit", 32'h1, 32'h0);
            end else begin
               e = exp_q.pop_front();
               chk("excp", {31'h0, excp}, {31'h0, e.is_excp});
               chk("ertn", {31'h0, ertn}, {31'h0, !e.is_excp});
               chk("ws_cancel", {31'h0, ws_cancel}, {31'h0, e.is_excp});
               if (e.is_excp) begin
                  chk("code", {26'h0, code}, {26'h0, e.code});
                  chk("subcode", {23'h0, subcode}, 32'h0);
                  chk("era", era, e.era);
                  chk("excpAboutAddr", {31'h0, excpAboutAddr}, {31'h0, e.about});
                  if (e.about) chk("badv_addr", badv_addr, e.badv);
                  chk("excp_tlbrefill", {31'h0, excp_tlbrefill}, {31'h0, e.tlbr});
               end else begin
                  chk("ertn_side", {30'h0, excpAboutAddr, excp_tlbrefill}, 32'h0);
               end
            end
         end else begin
            chk("idle_side", {29'h0, excpAboutAddr, excp_tlbrefill, ws_cancel}, 32'h0);
         end
         if (rif.redirect_valid && !prev_rv) begin
            if (tgt_q.size() == 0) begin
               chk("unexpected_redirect", 32'h1, 32'h0);
            end else begin
               held_pc = tgt_q.pop_front();
               chk("redirect_pc", rif.redirect_pc, held_pc);
            end
         end else if (rif.redirect_valid) begin
            chk("redirect_pc_hold", rif.redirect_pc, held_pc);
         end
      end
      prev_rv = rif.redirect_valid;
   end

   initial begin
      reset = 1'b1; ready = 1'b0;
      ws_valid = 1'b0; ws_excp_vec = 6'h0; ws_pc = 32'h0; ws_vaddr = 32'h0;
      ws_is_ertn = 1'b0; has_int = 1'b0;
      eentry_in = 32'h0; tlbrentry_in = 32'h0; era_in = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_redirect_valid", {31'h0, rif.redirect_valid}, 32'h0);
      chk("rst_redirect_pc", rif.redirect_pc, 32'h0);
      chk("rst_strobes", {26'h0, excp, ertn, excp_tlbrefill, excpAboutAddr, ws_cancel, flush}, 32'h0);
      chk("rst_csr_values", {era | badv_addr}, 32'h0);
      chk("rst_code", {17'h0, code, subcode}, 32'h0);
      mon_en = 1'b1;

      // SYSCALL
      eentry_in = 32'h1C00_8000;
      drv(1, 6'b001000, 32'h1C00_0100, 32'h0, 0, 0, 1);
      drv(0, 6'b000000, 32'h0, 32'h0, 0, 0, 1);
      drv(0, 6'b000000, 32'h0, 32'h0, 0, 0, 1);
      // ALE with interrupt: INT wins; then ALE alone
      drv(1, 6'b100000, 32'h1C00_0200, 32'h0000_1003, 0, 1, 1);
      drv(0, 6'b000000, 32'h0, 32'h0, 0, 1, 1);
      drv(1, 6'b100000, 32'h1C00_0204, 32'h0000_1003, 0, 0, 1);
      drv(0, 6'b000000, 32'h0, 32'h0, 0, 0, 1);
      // ERTN, then INE (bit 2) which must beat ERTN
      era_in = 32'h1C00_0204;
      drv(1, 6'b000000, 32'h1C00_0300, 32'h0, 1, 0, 1);
      drv(0, 6'b000000, 32'h0, 32'h0, 0, 0, 1);
      drv(1, 6'b000100, 32'h1C00_0304, 32'h0, 1, 0, 1);
      drv(0, 6'b000000, 32'h0, 32'h0, 0, 0, 1);
      // Handshake hold: a SYS during the hold must not commit
      drv(1, 6'b001000, 32'h1C00_0400, 32'h0, 0, 0, 0);
      drv(0, 6'b000000, 32'h0, 32'h0, 0, 0, 0);
      drv(1, 6'b001000, 32'h1C00_0404, 32'h0, 0, 1, 0);
      drv(0, 6'b000000, 32'h0, 32'h0, 0, 0, 0);
      drv(0, 6'b000000, 32'h0, 32'h0, 0, 0, 0);
      drv(0, 6'b000000, 32'h0, 32'h0, 0, 0, 0);
      drv(0, 6'b000000, 32'h0, 32'h0, 0, 0, 1);
      drv(0, 6'b000000, 32'h0, 32'h0, 0, 0, 1);
      // ADEF beats TLBR; TLBR alone (no commit without TLBR support)
      tlbrentry_in = 32'h1C00_F000;
      drv(1, 6'b000011, 32'h1C00_0500, 32'h0000_7777, 0, 0, 1);
      drv(0, 6'b000000, 32'h0, 32'h0, 0, 0, 1);
      drv(1, 6'b000010, 32'h1C00_0504, 32'h0000_8888, 0, 0, 1);
      drv(0, 6'b000000, 32'h0, 32'h0, 0, 0, 1);
      drv(0, 6'b000000, 32'h0, 32'h0, 0, 0, 1);
      // Reset during REDIRECT
      drv(1, 6'b001000, 32'h1C00_0600, 32'h0, 0, 0, 0);
      drv(0, 6'b000000, 32'h0, 32'h0, 0, 0, 0);
      reset = 1'b1;
      drv(0, 6'b000000, 32'h0, 32'h0, 0, 0, 0);
      reset = 1'b0;
      chk("reset_redirect_valid", {31'h0, rif.redirect_valid}, 32'h0);
      chk("reset_flush", {31'h0, flush}, 32'h0);
      chk("reset_redirect_pc", rif.redirect_pc, 32'h0);
      drv(0, 6'b000000, 32'h0, 32'h0, 0, 1, 0);

      // Random traffic
      for (int n = 0; n < 2000; n++) begin
         logic [5:0] vv;
         for (int b = 0; b < 6; b++) vv[b] = ($urandom_range(0, 7) == 0);
         eentry_in    = $urandom;
         tlbrentry_in = $urandom;
         era_in       = $urandom;
         reset        = ($urandom_range(0, 249) == 0);
         drv($urandom_range(0, 3) != 0, vv, $urandom, $urandom,
             $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 2) != 0);
      end
      reset = 1'b0;
      drv(0, 6'b000000, 32'h0, 32'h0, 0, 0, 1);
      drv(0, 6'b000000, 32'h0, 32'h0, 0, 0, 1);
      @(negedge clk);
      chk("pending_commits", exp_q.size(), 32'h0);
      chk("pending_redirects", tgt_q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
